vga_timing_out: RTL and testbench
=================================

# vga_timing_out

Pixel-timing generator and VGA output stage at the far end of the video path. It generates the 640x480@60 Hz raster counters (pixelX, pixelY, startOfFrame) that drive every drawing unit and the object mux. It then takes the composited 24-bit colour back from the mux and drives the board's DAC pins. Sync and blanking are delayed internally so that they line up with the colour returning from the pipelined drawing path.

## Interface
- PIPE_DELAY, 2, clocks from pixelX/pixelY issue to the matching colour on redIn/greenIn/blueIn; legal range 0..7.
- clk  in  1  pixel clock, 25.175 MHz nominal.
- resetN  in  1  reset, asynchronous, active-low.
- redIn / greenIn / blueIn  in  8 each  composited colour from the object mux.
- pixelX  out  11  horizontal counter, 0..799.
- pixelY  out  11  vertical counter, 0..524.
- startOfFrame  out  1  one-clock pulse at the first clock of vertical blanking.
- oVGA_R / oVGA_G / oVGA_B  out  8 each  DAC colour, registered.
- oVGA_HS / oVGA_VS  out  1 each  sync, active-low, registered.
- oVGA_BLANK_N  out  1  high during the visible area, registered.
- oVGA_SYNC_N  out  1  constant 0.
- oVGA_CLK  out  1  equal to clk.
- testPatternEn  in  1  exists only when VGA_TEST_PATTERN_EN is defined.

## Operation
- **Horizontal counter (hCount):**
  - Increments every clock.
  - 799 wraps to 0.
- **Vertical counter (vCount):**
  - Increments when hCount wraps.
  - 524 wraps to 0.
  - Both counters wrap on the same clock at (799,524) and go to (0,0).
- **pixelX/pixelY:** equal to hCount/vCount, combinational from the counter registers.
- **Horizontal regions (hCount):**
  - Visible 0..639.
  - Front porch 640..655.
  - Sync 656..751.
  - Back porch 752..799.
- **Vertical regions (vCount):**
  - Visible 0..479.
  - Front porch 480..489.
  - Sync 490..491.
  - Back porch 492..524.
- **Raw (undelayed) signals:**
  - hsRaw = !(656<=hCount<=751).
  - vsRaw = !(490<=vCount<=491).
  - visRaw = (hCount<640)&&(vCount<480).
- **startOfFrame:** high while (hCount,vCount)==(0,480). It is decoded from the counters, is not delayed, and lasts exactly one clock.
- **Delay line:**
  - hsRaw, vsRaw and visRaw pass through a PIPE_DELAY-stage shift register.
  - PIPE_DELAY=0 means a direct connection.
  - Stages reset to hs=1, vs=1, vis=0.
- **Output register:**
  - oVGA_HS/VS/BLANK_N take the delayed signals.
  - When delayed vis=1, oVGA_R/G/B take redIn/greenIn/blueIn.
  - When delayed vis=0, oVGA_R/G/B are forced to 0.
- **Reset values:**
  - Counters 0; pixelX=0, pixelY=0.
  - startOfFrame=0. While reset is held the counters sit at (0,0), so the decode is suppressed during reset.
  - oVGA_R/G/B=0.
  - oVGA_HS=1, oVGA_VS=1, oVGA_BLANK_N=0.
- **Reset mid-frame:**
  - All registers clear immediately (asynchronous).
  - After release, the raster restarts at (0,0).
  - The first PIPE_DELAY+1 output clocks show inactive sync and blank.

## Timing
- **Latency:** signals for a counter value issued at clock t appear on the output pins at t+PIPE_DELAY+1. This holds for HS, VS, BLANK_N and colour alike.
- **Colour sampling:** colour is sampled at t+PIPE_DELAY, i.e. the mux output registered at that edge.
- **Line:** 800 clocks; HS low for 96 consecutive clocks.
- **Frame:** 525 lines = 420000 clocks; VS low for 1600 consecutive clocks.
- **HS vs VS edges:** VS falls on the same clock as BLANK_N's line-start position for vCount=490 (hCount=0), delayed by the same latency as HS.
- **startOfFrame:** period exactly 420000 clocks. The first pulse comes 480*800 = 384000 clocks after reset release.

## Configuration
- **Macro:** VGA_TEST_PATTERN_EN.
- **When defined:**
  - Port testPatternEn exists.
  - The delay line additionally carries a 3-bit bar index, computed as hCount/80 by comparator chain, no divider.
  - With testPatternEn=1 and vis=1, the output colour is bar colour instead of the inputs.
  - Bars 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Blanking still forces 0.
- **When undefined:** the port and the bar logic are absent; output is always the input colour.

## Structure
- **Package vga_pkg:**
  - Timing localparams: H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800.
  - V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525.
  - Counter width 11.
  - typedef rgb24_t (struct of three 8-bit fields).
- **Sub-module vga_delay_line:**
  - Parameters WIDTH and DEPTH; generic shift register with asynchronous reset to a RESET_VAL parameter.
  - Used for {bar, vis, vs, hs}.

## Test plan
- **Reset:**
  - Hold resetN=0 for 10 clocks → pixelX=0, pixelY=0, oVGA_HS=1, oVGA_VS=1, oVGA_BLANK_N=0, RGB=0, startOfFrame=0.
  - Release → pixelX=1 after 1 clock.
- **HS timing (PIPE_DELAY=2):**
  - oVGA_HS falls 3 clocks after pixelX=656 and stays low exactly 96 clocks.
  - The line period is 800 clocks.
- **VS and startOfFrame:**
  - oVGA_VS is low for 1600 clocks starting 3 clocks after (0,490).
  - startOfFrame pulses once at (0,480), one clock wide.
  - Pulses are 420000 clocks apart.
- **Alignment:**
  - Bench feeds redIn = delayed-by-2 copy of pixelX[7:0] → oVGA_R equals the pixelX low byte of the same pixel, for every pixel where BLANK_N=1.
  - Pixel 639's value appears on the last BLANK_N-high clock.
- **Blank forcing:** redIn=greenIn=blueIn=FF constantly → RGB=FFFFFF only while BLANK_N=1; RGB=000000 on all 160 blank clocks per line and throughout lines 480..524.
- **Mid-frame reset and test pattern:**
  - Assert resetN=0 at (300,200) → outputs return to reset values within the same clock; after release the raster restarts at (0,0).
  - With VGA_TEST_PATTERN_EN and testPatternEn=1: pixels 0..79 give FFFFFF, 80..159 give FFFF00, and 560..639 give 000000.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants, colour type and test-bar helpers
// for the VGA output path. Bar helpers are only referenced when the
// VGA_TEST_PATTERN_EN macro is defined.
package vga_pkg;

  localparam int CNT_W = 11;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  localparam cnt_t H_VISIBLE = 11'd640;
  localparam cnt_t H_FP      = 11'd16;
  localparam cnt_t H_SYNC    = 11'd96;
  localparam cnt_t H_BP      = 11'd48;
  localparam cnt_t H_TOTAL   = 11'd800;

  localparam cnt_t V_VISIBLE = 11'd480;
  localparam cnt_t V_FP      = 11'd10;
  localparam cnt_t V_SYNC    = 11'd2;
  localparam cnt_t V_BP      = 11'd33;
  localparam cnt_t V_TOTAL   = 11'd525;

  // First and one-past-last counter values of each sync pulse.
  localparam cnt_t H_SYNC_START = H_VISIBLE + H_FP;
  localparam cnt_t H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam cnt_t V_SYNC_START = V_VISIBLE + V_FP;
  localparam cnt_t V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Eight 80-pixel colour bars across the visible line; a comparator chain
  // keeps a divider out of the pixel-rate path.
  function automatic logic [2:0] bar_index(input cnt_t h);
    logic [2:0] idx;
    if      (h >= 11'd560) idx = 3'd7;
    else if (h >= 11'd480) idx = 3'd6;
    else if (h >= 11'd400) idx = 3'd5;
    else if (h >= 11'd320) idx = 3'd4;
    else if (h >= 11'd240) idx = 3'd3;
    else if (h >= 11'd160) idx = 3'd2;
    else if (h >= 11'd80)  idx = 3'd1;
    else                   idx = 3'd0;
    return idx;
  endfunction

  function automatic rgb24_t bar_colour(input logic [2:0] idx);
    rgb24_t c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Generic shift register with asynchronous active-low reset to RESET_VAL.
// DEPTH=0 degenerates to a wire.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_direct
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ resetN;
      assign q_o = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift one stage per clock; every stage clears to the idle pattern.
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_out.sv
// 640x480@60 Hz raster generator and registered VGA DAC output stage.
// Sync/blank are delayed by PIPE_DELAY clocks to meet the colour returning
// from the drawing pipeline. Optional colour-bar generator is built when
// the VGA_TEST_PATTERN_EN macro is defined.
module vga_timing_out
  import vga_pkg::*;
#(
  parameter int PIPE_DELAY = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [7:0]       redIn,
  input  logic [7:0]       greenIn,
  input  logic [7:0]       blueIn,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             testPatternEn,
`endif
  output logic [CNT_W-1:0] pixelX,
  output logic [CNT_W-1:0] pixelY,
  output logic             startOfFrame,
  output logic [7:0]       oVGA_R,
  output logic [7:0]       oVGA_G,
  output logic [7:0]       oVGA_B,
  output logic             oVGA_HS,
  output logic             oVGA_VS,
  output logic             oVGA_BLANK_N,
  output logic             oVGA_SYNC_N,
  output logic             oVGA_CLK
);

  cnt_t hCount_q, hCount_d;
  cnt_t vCount_q, vCount_d;

  // Raster advance: h wraps every line, v steps on h wrap and wraps per frame.
  always_comb begin
    hCount_d = hCount_q + 11'd1;
    vCount_d = vCount_q;
    if (hCount_q == H_TOTAL - 11'd1) begin
      hCount_d = '0;
      if (vCount_q == V_TOTAL - 11'd1) vCount_d = '0;
      else                             vCount_d = vCount_q + 11'd1;
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hCount_q <= '0;
      vCount_q <= '0;
    end else begin
      hCount_q <= hCount_d;
      vCount_q <= vCount_d;
    end
  end

  assign pixelX       = hCount_q;
  assign pixelY       = vCount_q;
  assign startOfFrame = (hCount_q == '0) && (vCount_q == V_VISIBLE);

  logic hsRaw, vsRaw, visRaw;
  assign hsRaw  = !((hCount_q >= H_SYNC_START) && (hCount_q < H_SYNC_END));
  assign vsRaw  = !((vCount_q >= V_SYNC_START) && (vCount_q < V_SYNC_END));
  assign visRaw = (hCount_q < H_VISIBLE) && (vCount_q < V_VISIBLE);

  logic hsDly, vsDly, visDly;

`ifdef VGA_TEST_PATTERN_EN
  localparam int              DL_W   = 6;
  localparam logic [DL_W-1:0] DL_RST = 6'b000_0_1_1;
  logic [2:0]      barRaw, barDly;
  logic [DL_W-1:0] dlIn, dlOut;
  assign barRaw = bar_index(hCount_q);
  assign dlIn   = {barRaw, visRaw, vsRaw, hsRaw};
  assign {barDly, visDly, vsDly, hsDly} = dlOut;
`else
  localparam int              DL_W   = 3;
  localparam logic [DL_W-1:0] DL_RST = 3'b0_1_1;
  logic [DL_W-1:0] dlIn, dlOut;
  assign dlIn = {visRaw, vsRaw, hsRaw};
  assign {visDly, vsDly, hsDly} = dlOut;
`endif

  vga_delay_line #(
    .WIDTH     (DL_W),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (DL_RST)
  ) u_delay (
    .clk    (clk),
    .resetN (resetN),
    .d_i    (dlIn),
    .q_o    (dlOut)
  );

  rgb24_t rgb_q, rgb_d;
  logic   hs_q, vs_q, blankN_q;

  // Colour select: blanking forces black; otherwise mux input or test bar.
  always_comb begin
    rgb_d = '0;
    if (visDly) begin
      rgb_d = {redIn, greenIn, blueIn};
`ifdef VGA_TEST_PATTERN_EN
      if (testPatternEn) rgb_d = bar_colour(barDly);
`endif
    end
  end

  // DAC output register; idle state is sync inactive and blanked.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blankN_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      hs_q     <= hsDly;
      vs_q     <= vsDly;
      blankN_q <= visDly;
    end
  end

  assign oVGA_R       = rgb_q.r;
  assign oVGA_G       = rgb_q.g;
  assign oVGA_B       = rgb_q.b;
  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_BLANK_N = blankN_q;
  assign oVGA_SYNC_N  = 1'b0;
  assign oVGA_CLK     = clk;

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: random/structured colour stimulus compared every
// clock against a raster model built on a linear pixel index.
module tb_vga_timing_out;

  localparam int D     = 2;
  localparam int HT    = 800;
  localparam int FRAME = 800 * 525;

  logic        clk;
  logic        resetN;
  logic [7:0]  redIn, greenIn, blueIn;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame;
  logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
  logic        oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N, oVGA_CLK;
  logic        tp;

  vga_timing_out #(.PIPE_DELAY(D)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .redIn        (redIn),
    .greenIn      (greenIn),
    .blueIn       (blueIn),
`ifdef VGA_TEST_PATTERN_EN
    .testPatternEn(tp),
`endif
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .startOfFrame (startOfFrame),
    .oVGA_R       (oVGA_R),
    .oVGA_G       (oVGA_G),
    .oVGA_B       (oVGA_B),
    .oVGA_HS      (oVGA_HS),
    .oVGA_VS      (oVGA_VS),
    .oVGA_BLANK_N (oVGA_BLANK_N),
    .oVGA_SYNC_N  (oVGA_SYNC_N),
    .oVGA_CLK     (oVGA_CLK)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model state
  int          idx;          // linear raster index the counters show now
  int          pipe_q[$];    // issued indices still travelling to the pins
  bit          in_reset;
  int          mode;         // 0 random, 1 align, 2 all-FF
  logic [23:0] cur_rgb;
  int          e_h, e_v;
  bit          e_vis, e_hs, e_vs;
  logic [23:0] e_rgb;
  int          hs_run, vs_run;

`ifdef VGA_TEST_PATTERN_EN
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_model();
    idx = 0;
    pipe_q.delete();
    for (int i = 0; i < D; i++) pipe_q.push_back(-1);
  endtask

  task automatic drive_inputs();
    int pp;
    case (mode)
      1: begin
        pp = (idx + FRAME - 2) % FRAME;
        cur_rgb = {8'((pp % HT) & 255), 16'($urandom)};
      end
      2:       cur_rgb = 24'hFFFFFF;
      default: cur_rgb = 24'($urandom);
    endcase
    redIn   = cur_rgb[23:16];
    greenIn = cur_rgb[15:8];
    blueIn  = cur_rgb[7:0];
  endtask

  // Expected pin state for a given issued index (-1 = idle/reset).
  task automatic model_edge();
    int p;
    if (in_reset) begin
      p = -1;
    end else begin
      pipe_q.push_back(idx);
      p   = pipe_q.pop_front();
      idx = (idx + 1) % FRAME;
    end
    if (p < 0) begin
      e_h = -1; e_v = -1;
      e_vis = 0; e_hs = 1; e_vs = 1; e_rgb = 24'h0;
    end else begin
      e_h   = p % HT;
      e_v   = p / HT;
      e_hs  = !(e_h >= 656 && e_h <= 751);
      e_vs  = !(e_v >= 490 && e_v <= 491);
      e_vis = (e_h < 640) && (e_v < 480);
      e_rgb = 24'h0;
      if (e_vis) begin
        e_rgb = cur_rgb;
`ifdef VGA_TEST_PATTERN_EN
        if (tp) e_rgb = bars[e_h / 80];
`endif
      end
    end
  endtask

  task automatic check_outputs();
    chk("pixelX", 32'(pixelX), 32'(idx % HT));
    chk("pixelY", 32'(pixelY), 32'(idx / HT));
    chk("startOfFrame", 32'(startOfFrame), 32'(!in_reset && idx == 480 * HT));
    chk("hs_vs_blankn", 32'({oVGA_HS, oVGA_VS, oVGA_BLANK_N}), 32'({e_hs, e_vs, e_vis}));
    chk("rgb", 32'({oVGA_R, oVGA_G, oVGA_B}), 32'(e_rgb));
    if (mode == 1 && e_vis) chk("align_R", 32'(oVGA_R), 32'(e_h & 255));
    if (mode == 1 && e_vis && e_h == 639) chk("last_visible_R", 32'(oVGA_R), 32'h7F);
    if (!oVGA_HS) hs_run++;
    else if (hs_run != 0) begin
      chk("hs_low_width", 32'(hs_run), 32'd96);
      hs_run = 0;
    end
    if (!oVGA_VS) vs_run++;
    else if (vs_run != 0) begin
      chk("vs_low_width", 32'(vs_run), 32'd1600);
      vs_run = 0;
    end
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic cycle();
    drive_inputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pix"}, 32'({pixelY, pixelX}), 32'd0);
    chk({tag, "_sof"}, 32'(startOfFrame), 32'd0);
    chk({tag, "_sync"}, 32'({oVGA_HS, oVGA_VS, oVGA_BLANK_N}), 32'b110);
    chk({tag, "_rgb"}, 32'({oVGA_R, oVGA_G, oVGA_B}), 32'd0);
  endtask

  // Move the raster to (h,v); the output pipeline keeps its contents.
  task automatic jump(input int h, input int v);
    force dut.hCount_q = 11'(h);
    force dut.vCount_q = 11'(v);
    #1;
    release dut.hCount_q;
    release dut.vCount_q;
    idx = v * HT + h;
  endtask

  initial begin
    resetN = 1'b0;
    tp = 1'b0;
    mode = 0;
    redIn = '0; greenIn = '0; blueIn = '0;
    cur_rgb = '0;
    hs_run = 0; vs_run = 0;
    in_reset = 1;
    reset_model();
    @(negedge clk);

    // Power-on reset held for 10 clocks
    run(10);
    chk_idle("reset");
    chk("sync_n", 32'(oVGA_SYNC_N), 32'd0);

    resetN = 1'b1;
    in_reset = 0;
    reset_model();
    chk("release_pixelX", 32'(pixelX), 32'd0);

    // Random colour over two lines plus
    run(1700);
    // Colour tracks position two clocks late
    mode = 1;
    run(900);
    // Constant white input: only visible pixels may pass
    mode = 2;
    run(900);

    // Through vertical blanking, startOfFrame and the VS pulse
    jump(790, 469);
    mode = 0;
    run(19300);

    // Frame wrap (799,524) -> (0,0)
    jump(790, 524);
    mode = 2;
    run(900);

    // Asynchronous reset in the middle of a line
    mode = 0;
    jump(295, 200);
    for (int i = 0; i < 20 && idx != 200 * HT + 300; i++) cycle();
    chk("pos_before_reset", 32'({pixelY, pixelX}), 32'({11'd200, 11'd300}));
    resetN = 1'b0;
    #1;
    chk_idle("async_reset");
    in_reset = 1;
    reset_model();
    @(negedge clk);
    run(3);
    resetN = 1'b1;
    in_reset = 0;
    reset_model();
    chk("restart_pix", 32'({pixelY, pixelX}), 32'd0);
    run(1000);

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars replace the input on visible pixels only
    tp = 1'b1;
    run(900);
    tp = 1'b0;
    run(10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
